consumer_multi_load_transaction_generator: RTL and testbench

//  Parametrised successor of the single-FIFO consumer load issuer; serves NUM_CH consumer FIFOs behind one

---
 rtl/consumer_multi_load_transaction_generator_pkg.sv | 31 +++
 rtl/consumer_multi_load_transaction_generator_if.sv | 13 +
 rtl/consumer_multi_load_transaction_generator_rr_arbiter.sv | 25 ++
 rtl/consumer_multi_load_transaction_generator.sv | 73 +++++++
 tb/tb_consumer_multi_load_transaction_generator.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/consumer_multi_load_transaction_generator_pkg.sv
// consumer_multi_load_transaction_generator_pkg: shared FIFO pointer/address types and wrap-aware pointer helpers
package consumer_multi_load_transaction_generator_pkg;
    localparam int ADDR_W = 32;
    localparam int IDX_W = 8;
    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [IDX_W:0] occ_t;
    typedef struct packed {
        logic wrap;
        idx_t idx;
    } ptr_t;
    typedef struct packed {
        addr_t base;
        idx_t  length;
        ptr_t  tail;
    } fifo_config_t;
    function automatic int ch_w(int n);
        return n > 1 ? $clog2(n) : 1;
    endfunction
    function automatic ptr_t inc_ptr_n(ptr_t p, idx_t step, idx_t len);
        occ_t s = {1'b0, p.idx} + {1'b0, step};
        ptr_t r;
        r.wrap = s >= {1'b0, len} ? ~p.wrap : p.wrap;
        r.idx = s >= {1'b0, len} ? idx_t'(s - {1'b0, len}) : idx_t'(s);
        return r;
    endfunction
    function automatic occ_t fifo_occupancy(ptr_t tail, ptr_t head, idx_t len);
        return tail.wrap == head.wrap ? {1'b0, tail.idx} - {1'b0, head.idx}
                                      : {1'b0, len} - {1'b0, head.idx} + {1'b0, tail.idx};
    endfunction
endpackage

// File: rtl/consumer_multi_load_transaction_generator_if.sv
// consumer_multi_load_transaction_generator_if: load request and completion-ack bundle
interface consumer_multi_load_transaction_generator_if #(parameter int NUM_CH = 4);
    import consumer_multi_load_transaction_generator_pkg::*;
    localparam int CW = ch_w(NUM_CH);
    logic          trans_valid;
    logic          trans_ready;
    addr_t         trans_addr;
    logic [CW-1:0] trans_ch;
    logic          ack_valid;
    logic [CW-1:0] ack_ch;
    modport master (output trans_valid, trans_addr, trans_ch, input trans_ready, ack_valid, ack_ch);
    modport slave (input trans_valid, trans_addr, trans_ch, output trans_ready, ack_valid, ack_ch);
endinterface

// File: rtl/consumer_multi_load_transaction_generator_rr_arbiter.sv
// consumer_multi_load_transaction_generator_rr_arbiter: round-robin grant, pointer moves past the winner on advance
module consumer_multi_load_transaction_generator_rr_arbiter #(
    parameter int N = 4,
    localparam int W = N > 1 ? $clog2(N) : 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         advance,
    output logic [N-1:0] gnt,
    output logic [W-1:0] gnt_idx
);
    logic [W-1:0] ptr_q, ptr_d;
    always_comb begin
        gnt_idx = '0;
        for (int i = N - 1; i >= 0; i--)
            if (req[W'((int'(ptr_q) + i) % N)]) gnt_idx = W'((int'(ptr_q) + i) % N);
        gnt = '0;
        if (|req) gnt[gnt_idx] = 1'b1;
        ptr_d = advance ? (gnt_idx == W'(N - 1) ? '0 : gnt_idx + 1'b1) : ptr_q;
    end
    always_ff @(posedge clk) begin
        ptr_q <= rst ? '0 : ptr_d;
    end
endmodule

// File: rtl/consumer_multi_load_transaction_generator.sv
// consumer_multi_load_transaction_generator: per-channel full-line load issue with outstanding cap, round-robin into one registered request
module consumer_multi_load_transaction_generator
    import consumer_multi_load_transaction_generator_pkg::*;
#(
    parameter int NUM_CH = 4,
    parameter int ELEMS_PER_LINE = 2,
    parameter int LINE_BYTES = 16,
    parameter int MAX_OUTST = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  fifo_config_t [NUM_CH-1:0]      fifo_config_i,
    input  logic [NUM_CH-1:0]              ch_enable_i,
    consumer_multi_load_transaction_generator_if.master bus,
    output ptr_t [NUM_CH-1:0]              head_ptr_o,
    output logic                           err_o
);
    localparam int CW = ch_w(NUM_CH);
    localparam int OW = $clog2(MAX_OUTST + 1);
    localparam int EPL_SH = $clog2(ELEMS_PER_LINE);
    localparam int LB_SH = $clog2(LINE_BYTES);
    localparam idx_t STEP = idx_t'(ELEMS_PER_LINE);
    ptr_t [NUM_CH-1:0] issued;
    logic [NUM_CH-1:0] elig, gnt, ack_hit;
    logic [CW-1:0] gnt_idx, ch_q, ch_d;
    logic valid_q, valid_d, err_q, err_d, load, fire;
    addr_t addr_q, addr_d;
    assign load = ~valid_q | bus.trans_ready;
    assign fire = load & |elig;
    consumer_multi_load_transaction_generator_rr_arbiter #(.N(NUM_CH)) u_arb (
        .clk(clk), .rst(rst), .req(elig), .advance(fire), .gnt(gnt), .gnt_idx(gnt_idx)
    );
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        ptr_t issued_q, issued_d, acked_q, acked_d;
        logic [OW-1:0] outst_q, outst_d;
        assign elig[c] = ch_enable_i[c] && outst_q < OW'(MAX_OUTST) &&
            fifo_occupancy(fifo_config_i[c].tail, issued_q, fifo_config_i[c].length) >= occ_t'(ELEMS_PER_LINE);
        assign ack_hit[c] = bus.ack_valid && bus.ack_ch == CW'(c) && outst_q != '0;
        assign issued[c] = issued_q;
        assign head_ptr_o[c] = acked_q;
        always_comb begin
            issued_d = fire && gnt[c] ? inc_ptr_n(issued_q, STEP, fifo_config_i[c].length) : issued_q;
            acked_d = ack_hit[c] ? inc_ptr_n(acked_q, STEP, fifo_config_i[c].length) : acked_q;
            outst_d = outst_q + OW'(fire && gnt[c]) - OW'(ack_hit[c]);
        end
        always_ff @(posedge clk) begin
            issued_q <= rst ? '0 : issued_d;
            acked_q <= rst ? '0 : acked_d;
            outst_q <= rst ? '0 : outst_d;
        end
        assert property (@(posedge clk) !rst |-> outst_q <= OW'(MAX_OUTST));
        assert property (@(posedge clk) !rst && outst_q != '0 |=>
            rst || ($stable(fifo_config_i[c].base) && $stable(fifo_config_i[c].length)));
    end
    always_comb begin
        valid_d = load ? |elig : valid_q;
        ch_d = fire ? gnt_idx : ch_q;
        addr_d = fire ? fifo_config_i[gnt_idx].base + (addr_t'(issued[gnt_idx].idx >> EPL_SH) << LB_SH) : addr_q;
        err_d = err_q | (bus.ack_valid & ~|ack_hit);
    end
    always_ff @(posedge clk) begin
        valid_q <= rst ? 1'b0 : valid_d;
        ch_q <= rst ? '0 : ch_d;
        addr_q <= rst ? '0 : addr_d;
        err_q <= rst ? 1'b0 : err_d;
    end
    assign bus.trans_valid = valid_q;
    assign bus.trans_addr = addr_q;
    assign bus.trans_ch = ch_q;
    assign err_o = err_q;
    assert property (@(posedge clk) valid_q && !bus.trans_ready && !rst |=>
        rst || (valid_q && $stable(addr_q) && $stable(ch_q)));
endmodule

// File: tb/tb_consumer_multi_load_transaction_generator.sv
// tb_consumer_multi_load_transaction_generator: directed scenarios checked against a line-count transaction model
module tb_consumer_multi_load_transaction_generator;
    import consumer_multi_load_transaction_generator_pkg::*;
    localparam int NCH = 4, EPL = 2, LB = 16, MAXO = 4;
    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;
    fifo_config_t [NCH-1:0] cfg;
    logic [NCH-1:0] en;
    ptr_t [NCH-1:0] head;
    logic err;
    consumer_multi_load_transaction_generator_if #(.NUM_CH(NCH)) bus ();
    consumer_multi_load_transaction_generator #(
        .NUM_CH(NCH), .ELEMS_PER_LINE(EPL), .LINE_BYTES(LB), .MAX_OUTST(MAXO)
    ) dut (
        .clk(clk), .rst(rst), .fifo_config_i(cfg), .ch_enable_i(en), .bus(bus), .head_ptr_o(head), .err_o(err)
    );
    int base_a[NCH], len_a[NCH], tail_abs[NCH];
    int m_iss[NCH], m_ack[NCH], m_rr, m_addr, m_ch;
    bit m_valid, m_err, chk_en;
    int n_chk, n_pass, nreq;
    function automatic ptr_t ptr_of(int e, int l);
        ptr_t p;
        p.idx = idx_t'(e % l);
        p.wrap = ((e / l) % 2) == 1;
        return p;
    endfunction
    task automatic chk(string name, logic [63:0] got, logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    endtask
    task automatic step(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic apply_cfg();
        for (int c = 0; c < NCH; c++) begin
            cfg[c].base = addr_t'(base_a[c]);
            cfg[c].length = idx_t'(len_a[c]);
            cfg[c].tail = ptr_of(tail_abs[c], len_a[c]);
        end
    endtask
    task automatic do_reset();
        rst = 1'b1;
        bus.ack_valid = 1'b0;
        bus.ack_ch = '0;
        bus.trans_ready = 1'b1;
        en = '0;
        for (int c = 0; c < NCH; c++) begin
            base_a[c] = 'h1000 * (c + 1);
            len_a[c] = 8;
            tail_abs[c] = 0;
        end
        apply_cfg();
        step(2);
        rst = 1'b0;
    endtask
    // Model counts whole lines issued/acked per channel; addresses and pointers derive from those counts.
    always @(posedge clk) begin : model
        bit el [NCH];
        int w;
        bit ld;
        if (rst) begin
            m_valid = 0; m_err = 0; m_rr = 0; m_addr = 0; m_ch = 0;
            for (int c = 0; c < NCH; c++) begin m_iss[c] = 0; m_ack[c] = 0; end
        end else begin
            for (int c = 0; c < NCH; c++)
                el[c] = en[c] && (tail_abs[c] - m_iss[c] * EPL >= EPL) && (m_iss[c] - m_ack[c] < MAXO);
            ld = !m_valid || bus.trans_ready;
            if (bus.ack_valid) begin
                if (int'(bus.ack_ch) < NCH && m_iss[bus.ack_ch] - m_ack[bus.ack_ch] > 0) m_ack[bus.ack_ch]++;
                else m_err = 1;
            end
            if (ld) begin
                w = -1;
                for (int i = 0; i < NCH; i++)
                    if (w < 0 && el[(m_rr + i) % NCH]) w = (m_rr + i) % NCH;
                m_valid = w >= 0;
                if (w >= 0) begin
                    m_ch = w;
                    m_addr = base_a[w] + ((m_iss[w] * EPL) % len_a[w]) / EPL * LB;
                    m_iss[w]++;
                    m_rr = (w + 1) % NCH;
                end
            end
        end
    end
    always @(negedge clk) begin
        if (chk_en && !rst) begin
            chk("valid", bus.trans_valid, m_valid);
            if (m_valid) begin
                chk("addr", bus.trans_addr, m_addr);
                chk("ch", bus.trans_ch, m_ch);
            end
            for (int c = 0; c < NCH; c++) chk($sformatf("head%0d", c), head[c], ptr_of(m_ack[c] * EPL, len_a[c]));
            chk("err", err, m_err);
        end
    end
    initial begin
        n_chk = 0; n_pass = 0; chk_en = 0;
        do_reset();
        chk_en = 1;
        chk("rst_valid", bus.trans_valid, 0);
        chk("rst_err", err, 0);
        en = 4'b0001; tail_abs[0] = 4; apply_cfg();
        step(); chk("t1_v0", bus.trans_valid, 1); chk("t1_a0", bus.trans_addr, 'h1000);
        step(); chk("t1_a1", bus.trans_addr, 'h1010); chk("t1_ch", bus.trans_ch, 0);
        step(); chk("t1_idle", bus.trans_valid, 0);
        do_reset();
        en = 4'b0001; tail_abs[0] = 1; apply_cfg();
        step(3); chk("t2_partial", bus.trans_valid, 0);
        tail_abs[0] = 2; apply_cfg();
        step(); chk("t2_v", bus.trans_valid, 1); chk("t2_a", bus.trans_addr, 'h1000);
        step(); chk("t2_idle", bus.trans_valid, 0);
        do_reset();
        en = '1;
        for (int c = 0; c < NCH; c++) tail_abs[c] = 8;
        apply_cfg();
        for (int k = 0; k < 5; k++) begin step(); chk($sformatf("t3_ch%0d", k), bus.trans_ch, k % 4); end
        bus.trans_ready = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk("t3_hold_v", bus.trans_valid, 1); chk("t3_hold_ch", bus.trans_ch, 0); chk("t3_hold_a", bus.trans_addr, 'h1010);
        end
        bus.trans_ready = 1;
        step(); chk("t3_after_ch", bus.trans_ch, 1); chk("t3_after_a", bus.trans_addr, 'h2010);
        do_reset();
        en = 4'b0001; len_a[0] = 16; tail_abs[0] = 16; apply_cfg();
        nreq = 0;
        repeat (8) begin step(); if (bus.trans_valid) nreq++; end
        chk("t4_cap", nreq, 4);
        bus.ack_valid = 1; bus.ack_ch = 0; step(); bus.ack_valid = 0;
        chk("t4_head", head[0], 2);
        nreq = 0;
        repeat (4) begin step(); if (bus.trans_valid) nreq++; end
        chk("t4_more", nreq, 1);
        do_reset();
        en = 4'b0001;
        for (int k = 0; k < 5; k++) begin
            tail_abs[0] += 2; apply_cfg();
            step();
            chk($sformatf("t5_v%0d", k), bus.trans_valid, 1);
            chk($sformatf("t5_addr%0d", k), bus.trans_addr, 'h1000 + (k % 4) * 'h10);
            bus.ack_valid = 1; bus.ack_ch = 0; step(); bus.ack_valid = 0;
        end
        chk("t5_head", head[0], {1'b1, 8'd2});
        tail_abs[0] += 2; apply_cfg();
        step(); chk("t5_next", bus.trans_addr, 'h1010);
        do_reset();
        bus.ack_valid = 1; bus.ack_ch = 2; step(); bus.ack_valid = 0;
        chk("t6_err", err, 1); chk("t6_head", head[2], 0);
        en = 4'b0001; tail_abs[0] = 4; apply_cfg(); bus.trans_ready = 0;
        step(3);
        chk("t6_stall_v", bus.trans_valid, 1); chk("t6_stall_a", bus.trans_addr, 'h1000); chk("t6_sticky", err, 1);
        rst = 1; step();
        chk("t6_rst_v", bus.trans_valid, 0); chk("t6_rst_head", head[0], 0); chk("t6_rst_err", err, 0);
        rst = 0;
        step(3);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
